alu_arbiter: RTL and testbench

//  Shares one ALU instance between two requesters: port 0 is the pipeline EX

---
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the pipeline EX stage (port 0, high
// priority) and a secondary debug/test requester (port 1). Fixed priority
// with an anti-starvation counter that forces port 1 through after
// STARVE_LIMIT consecutive port-0 wins. The ALU result and flags are
// captured into a single response slot tagged with the winning port id.
module alu_arbiter #(
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  output logic              alu_en,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        rsp_flags
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             slot_free;
  logic             both_valid;
  logic             force1;
  logic             grant0;
  logic             grant1;

  // The slot can accept a new result when it is empty or being drained now.
  assign slot_free  = !rsp_valid || rsp_ready;
  assign both_valid = req0_valid && req1_valid;
  assign force1     = (starve_cnt == CNT_MAX);

  // Port 1 wins when alone, or when it has been passed over too many times.
  assign grant1 = slot_free && req1_valid && (!req0_valid || force1);
  assign grant0 = slot_free && req0_valid && !grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Steer the granted port's fields onto the ALU; park the ALU at zero when idle.
  always_comb begin
    alu_en     = grant0 || grant1;
    alu_opcode = '0;
    alu_in1    = '0;
    alu_in2    = '0;
    if (grant1) begin
      alu_opcode = req1_opcode;
      alu_in1    = req1_in1;
      alu_in2    = req1_in2;
    end else if (grant0) begin
      alu_opcode = req0_opcode;
      alu_in1    = req0_in1;
      alu_in2    = req0_in2;
    end
  end

  // Response slot: load on grant (even while draining), otherwise empty on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else if (grant0 || grant1) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant1;
      rsp_data  <= alu_out;
      rsp_flags <= alu_flags;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Count port-0 wins while port 1 waits; clear once port 1 is served or withdraws.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant1 || !req1_valid) begin
      starve_cnt <= '0;
    end else if (grant0 && both_valid && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios followed by randomized traffic, checked
// against a transaction-level model of the arbiter. A stand-in ALU is
// modelled here so that results and flags can be predicted.
module tb_alu_arbiter;

  localparam int DATA_W = 16;
  localparam int LIMIT  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_opcode;
  logic [DATA_W-1:0] req0_in1;
  logic [DATA_W-1:0] req0_in2;
  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_opcode;
  logic [DATA_W-1:0] req1_in1;
  logic [DATA_W-1:0] req1_in2;
  logic              alu_en;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        rsp_flags;

  int errors = 0;
  int checks = 0;

  // Model state: the response slot contents and how often port 1 was passed over.
  bit                m_valid;
  bit                m_id;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_flags;
  int                m_wait;

  alu_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Stand-in ALU returning {Z,V,N, result}.
  function automatic logic [18:0] aluModel(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a ^ b;
      4'd3: r = {15'd0, ^a};
      4'd4: r = a << b[3:0];
      4'd5: r = 16'($signed(a) >>> b[3:0]);
      4'd6: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
      default: r = {a[15:8] + b[15:8], a[7:0] + b[7:0]};
    endcase
    return {(r == 16'd0), v, r[15], r};
  endfunction

  assign {alu_flags, alu_out} = aluModel(alu_opcode, alu_in1, alu_in2);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_valid = 0;
    m_id    = 0;
    m_data  = '0;
    m_flags = '0;
    m_wait  = 0;
  endtask

  // Who should win right now: -1 none, 0 or 1.
  function automatic int expGrant();
    if (m_valid && !rsp_ready) return -1;
    if (req0_valid && req1_valid) return (m_wait == LIMIT) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // One clock cycle: inputs are already set at the falling edge.
  task automatic applyStimulus(output int obs_g, output int exp_g);
    logic [18:0] res;
    logic [3:0]  e_op;
    logic [15:0] e_a;
    logic [15:0] e_b;
    exp_g = expGrant();
    e_op = '0; e_a = '0; e_b = '0;
    if (exp_g == 0) begin e_op = req0_opcode; e_a = req0_in1; e_b = req0_in2; end
    if (exp_g == 1) begin e_op = req1_opcode; e_a = req1_in1; e_b = req1_in2; end
    #1;
    obs_g = req0_ready ? (req1_ready ? 2 : 0) : (req1_ready ? 1 : -1);
    checkOutput("req0_ready", req0_ready, exp_g == 0);
    checkOutput("req1_ready", req1_ready, exp_g == 1);
    checkOutput("alu_en", alu_en, exp_g != -1);
    checkOutput("alu_operands", {alu_opcode, alu_in1, alu_in2}, {e_op, e_a, e_b});
    @(posedge clk);
    if (exp_g != -1) begin
      res     = aluModel(e_op, e_a, e_b);
      m_valid = 1;
      m_id    = (exp_g == 1);
      m_data  = res[15:0];
      m_flags = res[18:16];
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    if (exp_g == 1 || !req1_valid) m_wait = 0;
    else if (exp_g == 0) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
    #1;
    checkOutput("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      checkOutput("rsp_id", rsp_id, m_id);
      checkOutput("rsp_data", rsp_data, m_data);
      checkOutput("rsp_flags", rsp_flags, m_flags);
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] randOperand();
    logic [15:0] edge_vals [4];
    edge_vals = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0001};
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    int og;
    int eg;
    int starve_seq [8];
    int reset_seq [4];
    logic [15:0] held_data;
    logic        held_id;
    logic [2:0]  held_flags;
    starve_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
    reset_seq  = '{0, 0, 0, 1};

    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 0; req0_opcode = '0; req0_in1 = '0; req0_in2 = '0;
    req1_valid = 0; req1_opcode = '0; req1_in1 = '0; req1_in2 = '0;
    resetModel();
    #2;
    checkOutput("reset_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flags}, '0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Lone port-1 ADD is granted in the same cycle and answered one cycle later.
    rsp_ready = 1;
    req1_valid = 1; req1_opcode = 4'd0; req1_in1 = 16'h0003; req1_in2 = 16'h0004;
    applyStimulus(og, eg);
    checkOutput("lone1_grant", og, 1);
    checkOutput("lone1_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flags[2]}, {1'b1, 1'b1, 16'h0007, 1'b0});
    req1_valid = 0;
    applyStimulus(og, eg);

    // Both ports valid continuously: port 1 forced every fourth grant.
    req0_valid = 1; req0_opcode = 4'd2; req0_in1 = 16'h1234; req0_in2 = 16'h00FF;
    req1_valid = 1; req1_opcode = 4'd0; req1_in1 = 16'h0100; req1_in2 = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(og, eg);
      checkOutput($sformatf("starve_seq%0d", i), og, starve_seq[i]);
    end
    req1_valid = 0;

    // Backpressure: slot stays full and frozen while the consumer stalls.
    req0_opcode = 4'd4; req0_in1 = 16'h0003; req0_in2 = 16'h0002;
    applyStimulus(og, eg);
    checkOutput("hold_first_grant", og, 0);
    held_data = rsp_data; held_id = rsp_id; held_flags = rsp_flags;
    rsp_ready = 0;
    req0_opcode = 4'd1; req0_in1 = 16'h0009; req0_in2 = 16'h0004;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(og, eg);
      checkOutput("hold_no_grant", og, -1);
      checkOutput("hold_stable", {rsp_valid, rsp_id, rsp_data, rsp_flags},
                  {1'b1, held_id, held_data, held_flags});
    end
    rsp_ready = 1;
    applyStimulus(og, eg);
    checkOutput("release_grant", og, 0);
    checkOutput("release_valid", rsp_valid, 1'b1);
    checkOutput("release_data", rsp_data, 16'h0005);

    // Signed overflow and zero flags from SUB.
    req0_opcode = 4'd1; req0_in1 = 16'h8000; req0_in2 = 16'h0001;
    applyStimulus(og, eg);
    checkOutput("sub_ovf_V", rsp_flags[1], 1'b1);
    req0_in1 = 16'h0005; req0_in2 = 16'h0005;
    applyStimulus(og, eg);
    checkOutput("sub_zero", {rsp_data, rsp_flags[2]}, {16'h0000, 1'b1});

    // Reset mid-cycle with a full slot and a partly built starvation count.
    req1_valid = 1; req1_opcode = 4'd2; req1_in1 = 16'hAAAA; req1_in2 = 16'h5555;
    applyStimulus(og, eg);
    applyStimulus(og, eg);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_reset_valid", rsp_valid, 1'b0);
    checkOutput("mid_reset_data", rsp_data, 16'h0000);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(og, eg);
      checkOutput($sformatf("post_reset_seq%0d", i), og, reset_seq[i]);
    end

    // Idle: ALU parked at zero and the slot drains empty.
    req0_valid = 0; req1_valid = 0;
    applyStimulus(og, eg);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(og, eg);
      checkOutput("idle_alu", {alu_en, alu_opcode, alu_in1, alu_in2}, '0);
      checkOutput("idle_rsp_valid", rsp_valid, 1'b0);
    end

    // Randomized traffic: requesters hold fields until granted.
    for (int n = 0; n < 400; n++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1; req0_opcode = 4'($urandom_range(0, 7));
        req0_in1 = randOperand(); req0_in2 = randOperand();
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1; req1_opcode = 4'($urandom_range(0, 7));
        req1_in1 = randOperand(); req1_in2 = randOperand();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(og, eg);
      if (eg == 0) req0_valid = 0;
      if (eg == 1) req1_valid = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
